audio_dac_stream: RTL and testbench

- Parametrised stereo I2S/left-justified DAC serializer. Generates BCK, LRCK and DATA synchronously from iCLK_18_4 using clock-enable counters; no derived clocks.
- Upstream logic (synth voice mixer) pushes stereo sample pairs into an internal FIFO through a valid/ready handshake.
- Replaces the fixed-source, 16-bit-only DAC driver. Adds underrun detection, a mute control and a selectable serial format.

---
 rtl/audio_dac_stream_if.sv | 12 +
 rtl/audio_dac_stream.sv | 196 +++++++++++++++++++
 tb/tb_audio_dac_stream.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/audio_dac_stream_if.sv
// Stereo sample-pair handshake between the voice mixer (master) and the DAC serializer (slave).
interface audio_dac_stream_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] sample_l;
  logic [DATA_WIDTH-1:0] sample_r;
  logic                  valid;
  logic                  ready;

  modport master (output sample_l, output sample_r, output valid, input ready);
  modport slave  (input sample_l, input sample_r, input valid, output ready);
endinterface

// File: rtl/audio_dac_stream.sv
// Stereo I2S / left-justified DAC serializer fed by a stereo-pair FIFO; BCK/LRCK derived by clock enables.
// Optional built-in 1 kHz sine test tone is enabled by defining AUDIO_DAC_STREAM_TONE_EN.
module audio_dac_stream #(
  parameter int REF_CLK     = 18432000,
  parameter int SAMPLE_RATE = 48000,
  parameter int DATA_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int I2S_MODE    = 1
) (
  input  logic                          iCLK_18_4,
  input  logic                          iRST_N,
  audio_dac_stream_if.slave             samples,
  input  logic                          iMute,
`ifdef AUDIO_DAC_STREAM_TONE_EN
  input  logic                          iTone,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   oFifo_Level,
  output logic                          oUnderrun,
  output logic                          oAUD_BCK,
  output logic                          oAUD_LRCK,
  output logic                          oAUD_DATA
);

  localparam int HALF  = REF_CLK / (SAMPLE_RATE * DATA_WIDTH * 4);
  localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int SLOTS = 2 * DATA_WIDTH;
  localparam int S_W   = $clog2(SLOTS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DIV_W-1:0] div_cnt;
  logic [S_W-1:0]   slot;
  logic [S_W-1:0]   slot_next;
  logic [S_W-1:0]   bit_sel;
  logic [SLOTS-1:0] frame;
  logic [SLOTS-1:0] frame_next;
  logic [SLOTS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             bck_fall;
  logic             frame_start;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             underrun_next;
  logic             data_next;
  logic             tone_sel;
  logic [DATA_WIDTH-1:0] tone_word;

`ifdef AUDIO_DAC_STREAM_TONE_EN
  logic [5:0]  tone_idx;
  logic [3:0]  tone_k;
  logic        tone_neg;
  logic [15:0] tone_mag;
  logic [15:0] tone_val;

  // First quadrant of a 48-point sine, amplitude 32767; the rest follows by symmetry.
  function automatic logic [15:0] quarter_sine(input logic [3:0] k);
    case (k)
      4'd0:    quarter_sine = 16'd0;
      4'd1:    quarter_sine = 16'd4277;
      4'd2:    quarter_sine = 16'd8481;
      4'd3:    quarter_sine = 16'd12539;
      4'd4:    quarter_sine = 16'd16383;
      4'd5:    quarter_sine = 16'd19947;
      4'd6:    quarter_sine = 16'd23170;
      4'd7:    quarter_sine = 16'd25996;
      4'd8:    quarter_sine = 16'd28377;
      4'd9:    quarter_sine = 16'd30273;
      4'd10:   quarter_sine = 16'd31650;
      4'd11:   quarter_sine = 16'd32487;
      4'd12:   quarter_sine = 16'd32767;
      default: quarter_sine = 16'd0;
    endcase
  endfunction

  assign tone_sel = iTone && !iMute;

  always_comb begin
    tone_neg = 1'b0;
    tone_k   = 4'(tone_idx);
    if (tone_idx <= 6'd12) begin
      tone_k = 4'(tone_idx);
    end else if (tone_idx <= 6'd24) begin
      tone_k = 4'(6'd24 - tone_idx);
    end else if (tone_idx <= 6'd36) begin
      tone_k   = 4'(tone_idx - 6'd24);
      tone_neg = 1'b1;
    end else begin
      tone_k   = 4'(6'd48 - tone_idx);
      tone_neg = 1'b1;
    end
    tone_mag  = quarter_sine(tone_k);
    tone_val  = tone_neg ? (16'd0 - tone_mag) : tone_mag;
    tone_word = DATA_WIDTH'(tone_val) << (DATA_WIDTH - 16);
  end

  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      tone_idx <= '0;
    end else if (frame_start && tone_sel) begin
      tone_idx <= (tone_idx == 6'd47) ? 6'd0 : tone_idx + 6'd1;
    end
  end
`else
  assign tone_sel  = 1'b0;
  assign tone_word = '0;
`endif

  assign fifo_empty    = (level == '0);
  assign samples.ready = (level != LVL_W'(FIFO_DEPTH));
  assign push          = samples.valid && samples.ready;
  assign oFifo_Level   = level;

  // Slot sequencing, frame loading and next serial bit, all decided in the BCK falling-edge clock.
  always_comb begin
    bck_fall      = oAUD_BCK && (div_cnt == DIV_W'(HALF - 1));
    frame_start   = bck_fall && (slot == S_W'(SLOTS - 1));
    slot_next     = slot;
    frame_next    = frame;
    pop           = 1'b0;
    underrun_next = 1'b0;
    bit_sel       = '0;
    data_next     = 1'b0;
    if (bck_fall) begin
      slot_next = frame_start ? '0 : slot + S_W'(1);
    end
    if (frame_start) begin
      if (tone_sel) begin
        frame_next = {tone_word, tone_word};
      end else begin
        frame_next    = (iMute || fifo_empty) ? '0 : mem[rd_ptr];
        pop           = !fifo_empty;
        underrun_next = fifo_empty;
      end
    end
    // I2S slot 0 still carries the previous frame's right-channel LSB.
    if (I2S_MODE != 0) begin
      bit_sel   = S_W'(SLOTS) - slot_next;
      data_next = (slot_next == '0) ? frame[0] : frame_next[bit_sel];
    end else begin
      bit_sel   = S_W'(SLOTS - 1) - slot_next;
      data_next = frame_next[bit_sel];
    end
  end

  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      div_cnt   <= '0;
      oAUD_BCK  <= 1'b0;
      slot      <= '0;
      frame     <= '0;
      oAUD_LRCK <= 1'b0;
      oAUD_DATA <= 1'b0;
      oUnderrun <= 1'b0;
    end else begin
      if (div_cnt == DIV_W'(HALF - 1)) begin
        div_cnt  <= '0;
        oAUD_BCK <= !oAUD_BCK;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      slot      <= slot_next;
      frame     <= frame_next;
      oUnderrun <= underrun_next;
      if (bck_fall) begin
        oAUD_LRCK <= (slot_next >= S_W'(DATA_WIDTH));
        oAUD_DATA <= data_next;
      end
    end
  end

  always_ff @(posedge iCLK_18_4) begin
    if (push) begin
      mem[wr_ptr] <= {samples.sample_l, samples.sample_r};
    end
  end

  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_dac_stream.sv
// Randomized bench for audio_dac_stream: one I2S and one left-justified instance driven identically,
// compared every clock against a frame-level model derived from the clock count since reset.
module tb_audio_dac_stream;
  localparam int W          = 16;
  localparam int DEPTH      = 8;
  localparam int BCK_HALF   = 6;
  localparam int FRAME_CLKS = 384;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sample_l = '0;
  logic [W-1:0] sample_r = '0;
  logic         valid = 1'b0;
  logic         mute = 1'b0;
  logic         tone = 1'b0;

  logic [3:0] level_i2s, level_lj;
  logic       und_i2s, und_lj, bck_i2s, bck_lj, lrck_i2s, lrck_lj, data_i2s, data_lj;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          n = 0;
  logic [31:0] mq[$];
  logic [31:0] cur_word = '0;
  logic [31:0] prev_word = '0;
  bit          cur_known = 1'b1;
  bit          prev_known = 1'b1;
  bit          und_exp = 1'b0;
  int          tone_idx = 0;

  always #5 clk = ~clk;

  audio_dac_stream_if #(.DATA_WIDTH(W)) bus_i2s ();
  audio_dac_stream_if #(.DATA_WIDTH(W)) bus_lj ();

  assign bus_i2s.sample_l = sample_l;
  assign bus_i2s.sample_r = sample_r;
  assign bus_i2s.valid    = valid;
  assign bus_lj.sample_l  = sample_l;
  assign bus_lj.sample_r  = sample_r;
  assign bus_lj.valid     = valid;

  audio_dac_stream #(.DATA_WIDTH(W), .FIFO_DEPTH(DEPTH), .I2S_MODE(1)) dut_i2s (
    .iCLK_18_4(clk), .iRST_N(rst_n), .samples(bus_i2s), .iMute(mute),
`ifdef AUDIO_DAC_STREAM_TONE_EN
    .iTone(tone),
`endif
    .oFifo_Level(level_i2s), .oUnderrun(und_i2s), .oAUD_BCK(bck_i2s),
    .oAUD_LRCK(lrck_i2s), .oAUD_DATA(data_i2s)
  );

  audio_dac_stream #(.DATA_WIDTH(W), .FIFO_DEPTH(DEPTH), .I2S_MODE(0)) dut_lj (
    .iCLK_18_4(clk), .iRST_N(rst_n), .samples(bus_lj), .iMute(mute),
`ifdef AUDIO_DAC_STREAM_TONE_EN
    .iTone(tone),
`endif
    .oFifo_Level(level_lj), .oUnderrun(und_lj), .oAUD_BCK(bck_lj),
    .oAUD_LRCK(lrck_lj), .oAUD_DATA(data_lj)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at clock %0d: observed 0x%0h expected 0x%0h", tag, n, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [W-1:0] l, input logic [W-1:0] r);
    valid    = v;
    sample_l = l;
    sample_r = r;
  endtask

  task automatic waitCycles(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  // Model: edge n since reset release; a frame starts every 384 edges, where the queue head is consumed.
  task automatic modelStep();
    bit fs;
    bit do_push;
    logic [15:0] tv;
    if (!rst_n) begin
      n = 0;
      mq.delete();
      cur_word   = '0;
      prev_word  = '0;
      cur_known  = 1'b1;
      prev_known = 1'b1;
      und_exp    = 1'b0;
      tone_idx   = 0;
    end else begin
      n++;
      fs      = (n % FRAME_CLKS == 0);
      do_push = valid && (mq.size() < DEPTH);
      und_exp = 1'b0;
      if (fs) begin
        prev_word  = cur_word;
        prev_known = cur_known;
        cur_known  = 1'b1;
        if (tone && !mute) begin
          tv        = (tone_idx == 12) ? 16'h7FFF : (tone_idx == 36) ? 16'h8001 : 16'h0000;
          cur_word  = {tv, tv};
          cur_known = (tone_idx % 12 == 0);
          tone_idx  = (tone_idx + 1) % 48;
        end else if (mq.size() == 0) begin
          cur_word = '0;
          und_exp  = 1'b1;
        end else begin
          cur_word = mq.pop_front();
          if (mute) cur_word = '0;
        end
      end
      if (do_push) mq.push_back({sample_l, sample_r});
    end
  endtask

  task automatic checkAll();
    int slot;
    slot = (n / (2 * BCK_HALF)) % 32;
    checkOutput("bck_i2s", 32'(bck_i2s), 32'((n / BCK_HALF) % 2));
    checkOutput("bck_lj", 32'(bck_lj), 32'((n / BCK_HALF) % 2));
    checkOutput("lrck_i2s", 32'(lrck_i2s), 32'(slot >= W));
    checkOutput("lrck_lj", 32'(lrck_lj), 32'(slot >= W));
    checkOutput("underrun_i2s", 32'(und_i2s), 32'(und_exp));
    checkOutput("underrun_lj", 32'(und_lj), 32'(und_exp));
    checkOutput("ready_i2s", 32'(bus_i2s.ready), 32'(mq.size() != DEPTH));
    checkOutput("ready_lj", 32'(bus_lj.ready), 32'(mq.size() != DEPTH));
    checkOutput("level_i2s", 32'(level_i2s), 32'(mq.size()));
    checkOutput("level_lj", 32'(level_lj), 32'(mq.size()));
    if (cur_known) checkOutput("data_lj", 32'(data_lj), 32'(cur_word[5'(31 - slot)]));
    if (slot == 0) begin
      if (prev_known) checkOutput("data_i2s_slot0", 32'(data_i2s), 32'(prev_word[0]));
    end else if (cur_known) begin
      checkOutput("data_i2s", 32'(data_i2s), 32'(cur_word[5'(32 - slot)]));
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    modelStep();
  end

  initial forever begin
    @(negedge clk);
    checkAll();
  end

  initial begin
    $display("[TB] starting audio_dac_stream bench");
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(800);

    // Known pair ahead of a frame start
    applyStimulus(1'b1, 16'hA5F0, 16'h0F0F);
    waitCycles(1);
    applyStimulus(1'b0, '0, '0);
    waitCycles(900);

    // Fill from just after a frame start and keep pushing across the next one
    while (n % FRAME_CLKS != 5) waitCycles(1);
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'b1, W'($urandom), W'($urandom));
      waitCycles(1);
    end
    applyStimulus(1'b0, '0, '0);
    waitCycles(100);

    // Mid-frame reset, then three muted pairs followed by an underrun frame
    rst_n = 1'b0;
    waitCycles(3);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, W'($urandom), W'($urandom));
      waitCycles(1);
    end
    applyStimulus(1'b0, '0, '0);
    mute = 1'b1;
    waitCycles(4 * FRAME_CLKS + 60);
    mute = 1'b0;

    // Random traffic: busier first half, sparse second half, occasional muted frames
    for (int i = 0; i < 30 * FRAME_CLKS; i++) begin
      if (n % FRAME_CLKS == 200) mute = ($urandom_range(0, 3) == 0);
      applyStimulus($urandom_range(0, (i < 15 * FRAME_CLKS) ? 149 : 599) == 0,
                    W'($urandom), W'($urandom));
      waitCycles(1);
    end
    applyStimulus(1'b0, '0, '0);
    mute = 1'b0;
    waitCycles(10);

`ifdef AUDIO_DAC_STREAM_TONE_EN
    rst_n = 1'b0;
    waitCycles(3);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, W'($urandom), W'($urandom));
      waitCycles(1);
    end
    applyStimulus(1'b0, '0, '0);
    tone = 1'b1;
    waitCycles(38 * FRAME_CLKS);
    tone = 1'b0;
    waitCycles(10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
